// File: rtl/keypad_encoder_if.sv
// Keypad pin and control-unit bundle for keypad_encoder.
// master = encoder (drives columns and key outputs); slave = board rows plus the control unit.
interface keypad_encoder_if;
    logic [3:0] Row;
    logic [3:0] Col;
    logic [2:0] value;
    logic [3:0] digit;
    logic       trig;
    logic       KeyHeld;

    modport master (input Row, output Col, value, digit, trig, KeyHeld);
    modport slave  (output Row, input Col, value, digit, trig, KeyHeld);
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 calculator keypad scanner, debouncer and key-class encoder with registered trig strobe.
// Optional AUTO_REPEAT_EN: held digit keys re-strobe every REPEAT_DLY cycles.
module keypad_encoder #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 20000,
    parameter int TRIG_W     = 4,
    parameter int REPEAT_DLY = 5000000
) (
    input  logic             CLK,
    input  logic             Reset,
    keypad_encoder_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int TRG_W = $clog2(TRIG_W + 1);

    localparam logic [2:0] S_SCAN   = 3'd0;
    localparam logic [2:0] S_DEB    = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_REL    = 3'd5;

    localparam logic [2:0] V_NONE  = 3'd0;
    localparam logic [2:0] V_DIGIT = 3'd1;
    localparam logic [2:0] V_ADD   = 3'd2;
    localparam logic [2:0] V_CE    = 3'd5;
    localparam logic [2:0] V_CA    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [TRG_W-1:0] trg_q, trg_d;
    logic [2:0]       value_q, value_d;
    logic [3:0]       digit_q, digit_d;
    logic             trig_q, trig_d;
    logic             held_q, held_d;

    logic [1:0]       key_r;
    logic [2:0]       key_v;
    logic [3:0]       key_d;
    logic             unused_key;
    logic             rep_fire;

    function automatic logic [1:0] row_index(input logic [3:0] row_n);
        case (row_n)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [2:0] key_value(input logic [1:0] r, input logic [1:0] c);
        if (r != 2'd3) return (c == 2'd3) ? (V_ADD + {1'b0, r}) : V_DIGIT;
        case (c)
            2'd0:    return V_CE;
            2'd1:    return V_DIGIT;
            2'd2:    return V_CA;
            default: return V_NONE;
        endcase
    endfunction

    function automatic logic [3:0] key_digit(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] rr;
        rr = {2'b00, r};
        if (r == 2'd3) return 4'd0;
        return rr + rr + rr + {2'b00, c} + 4'd1;
    endfunction

    assign key_r      = row_index(row_q);
    assign key_v      = key_value(key_r, col_q);
    assign key_d      = key_digit(key_r, col_q);
    // (r3, c3) has no function: it is held and released but never strobed
    assign unused_key = (row_q == 4'b0111) && (col_q == 2'd3);

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DLY + 1);
    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_ok;

    assign rep_ok   = (value_q == V_DIGIT) && !unused_key;
    assign rep_fire = rep_ok && (rep_q >= REP_W'(REPEAT_DLY - 1));

    // Counts from each strobe entry through STROBE and HOLD, so repeats are REPEAT_DLY apart
    always_comb begin
        rep_d = '0;
        if (rep_ok) begin
            if (state_q == S_STROBE) rep_d = rep_q + 1'b1;
            else if (state_q == S_HOLD && kp.Row != 4'hF && !rep_fire) rep_d = rep_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`else
    assign rep_fire = (REPEAT_DLY < 0);
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        div_d   = div_q;
        deb_d   = deb_q;
        trg_d   = trg_q;
        value_d = value_q;
        digit_d = digit_q;
        held_d  = held_q;
        // trig lags the STROBE state by one cycle, so value/digit lead its rising edge
        trig_d  = (state_q == S_STROBE);
        case (state_q)
            S_SCAN: begin
                if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    if ($onehot(~kp.Row)) begin
                        row_d   = kp.Row;
                        deb_d   = '0;
                        state_d = S_DEB;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DEB: begin
                if (kp.Row != row_q) begin
                    div_d   = '0;
                    state_d = S_SCAN;
                end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_d = '0;
                    if (unused_key) begin
                        held_d  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_SETUP;
                    end
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_SETUP: begin
                value_d = key_v;
                if (key_v == V_DIGIT) digit_d = key_d;
                held_d  = 1'b1;
                trg_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (trg_q == TRG_W'(TRIG_W - 1)) begin
                    trg_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    trg_d = trg_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (kp.Row == 4'hF) begin
                    deb_d   = '0;
                    state_d = S_REL;
                end else if (rep_fire) begin
                    trg_d   = '0;
                    state_d = S_STROBE;
                end
            end
            S_REL: begin
                if (kp.Row != 4'hF) begin
                    deb_d = '0;
                end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_d   = '0;
                    div_d   = '0;
                    held_d  = 1'b0;
                    col_d   = col_q + 1'b1;
                    state_d = S_SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_SCAN;
            col_q   <= 2'd0;
            row_q   <= 4'hF;
            div_q   <= '0;
            deb_q   <= '0;
            trg_q   <= '0;
            value_q <= V_NONE;
            digit_q <= 4'd0;
            trig_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            div_q   <= div_d;
            deb_q   <= deb_d;
            trg_q   <= trg_d;
            value_q <= value_d;
            digit_q <= digit_d;
            trig_q  <= trig_d;
            held_q  <= held_d;
        end
    end

    assign kp.Col     = ~(4'b0001 << col_q);
    assign kp.value   = value_q;
    assign kp.digit   = digit_q;
    assign kp.trig    = trig_q;
    assign kp.KeyHeld = held_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: key-matrix model, timeline reference model checked every cycle,
// plus directed literal checks.
module tb_keypad_encoder;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int TW       = 2;
    localparam int DLY      = 40;

    logic        CLK   = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c held down
    bit          cmp_on = 1'b0;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          rises  = 0;
    logic        trig_prev = 1'b0;

    int val_tab [16] = '{1, 1, 1, 2,  1, 1, 1, 3,  1, 1, 1, 4,  5, 1, 6, 0};
    int dig_tab [16] = '{1, 2, 3, 0,  4, 5, 6, 0,  7, 8, 9, 0,  0, 0, 0, 0};

    logic [3:0] m_col;
    logic [2:0] m_value;
    logic [3:0] m_digit;
    logic       m_trig;
    logic       m_held;
    int         k;
    bit         ab;

    keypad_encoder_if kp_if ();

    keypad_encoder #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_CYCLES(DEB),
        .TRIG_W    (TW),
        .REPEAT_DLY(DLY)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .kp   (kp_if)
    );

    always #5 CLK = ~CLK;

    // A row reads low when any pressed key on it sits in a column driven low
    function automatic logic [3:0] matrix_rows(input logic [15:0] p, input logic [3:0] col);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (p[ri*4+ci] && !col[ci]) r[ri] = 1'b0;
        return r;
    endfunction

    assign kp_if.Row = matrix_rows(pressed, kp_if.Col);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK or posedge Reset);
        m_trig = 1'b0;
        if (Reset) ab = 1'b1;
    endtask

    task automatic strobe(inout int since);
        for (int i = 0; i < TW; i++) begin
            tick();
            if (ab) return;
            m_trig = 1'b1;
            since++;
        end
    endtask

    // Reference timeline: one pass per column dwell; returns only when reset interrupts it
    task automatic model_run();
        logic [3:0] r;
        int         row, idx, n, since;
        bit         ok;
        forever begin
            m_col = ~(4'b0001 << k);
            for (int i = 0; i < SCAN_DIV; i++) begin
                tick();
                if (ab) return;
            end
            r = matrix_rows(pressed, m_col);
            if ($countones(~r) != 1) begin
                k = (k + 1) % 4;
                continue;
            end
            ok = 1'b1;
            for (int i = 0; i < DEB; i++) begin
                tick();
                if (ab) return;
                if (matrix_rows(pressed, m_col) != r) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (!ok) continue;
            row = 0;
            for (int j = 0; j < 4; j++) if (!r[j]) row = j;
            idx   = row * 4 + k;
            since = 0;
            if (idx == 15) begin
                m_held = 1'b1;
            end else begin
                tick();
                if (ab) return;
                m_value = 3'(val_tab[idx]);
                if (val_tab[idx] == 1) m_digit = 4'(dig_tab[idx]);
                m_held = 1'b1;
                strobe(since);
                if (ab) return;
            end
            forever begin
                tick();
                if (ab) return;
                since++;
                if (matrix_rows(pressed, m_col) == 4'hF) break;
`ifdef AUTO_REPEAT_EN
                if (val_tab[idx] == 1 && since == DLY) begin
                    since = 0;
                    strobe(since);
                    if (ab) return;
                end
`endif
            end
            n = 0;
            while (n < DEB) begin
                tick();
                if (ab) return;
                if (matrix_rows(pressed, m_col) == 4'hF) n++;
                else n = 0;
            end
            m_held = 1'b0;
            k = (k + 1) % 4;
        end
    endtask

    always begin
        m_col = 4'b1110; m_value = '0; m_digit = '0; m_trig = 1'b0; m_held = 1'b0;
        k = 0; ab = 1'b0;
        wait (!Reset);
        model_run();
    end

    always @(negedge CLK) begin
        if (kp_if.trig && !trig_prev) rises++;
        trig_prev = kp_if.trig;
        if (cmp_on) begin
            chk("Col",     {28'd0, kp_if.Col},     {28'd0, m_col});
            chk("value",   {29'd0, kp_if.value},   {29'd0, m_value});
            chk("digit",   {28'd0, kp_if.digit},   {28'd0, m_digit});
            chk("trig",    {31'd0, kp_if.trig},    {31'd0, m_trig});
            chk("KeyHeld", {31'd0, kp_if.KeyHeld}, {31'd0, m_held});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic key(input int r, input int c);
        pressed[r*4+c] = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r0;
        int exp9;
        #2 Reset = 1'b1;
        #1 cmp_on = 1'b1;
        wait_cyc(3);
        Reset = 1'b0;
        chk("rst_col",  {28'd0, kp_if.Col}, 32'hE);
        chk("rst_val",  {29'd0, kp_if.value}, 32'd0);
        chk("rst_trig", {31'd0, kp_if.trig}, 32'd0);
        chk("rst_held", {31'd0, kp_if.KeyHeld}, 32'd0);

        // idle scan rotation
        wait_cyc(4); chk("scan_c1", {28'd0, kp_if.Col}, 32'hD);
        wait_cyc(4); chk("scan_c2", {28'd0, kp_if.Col}, 32'hB);
        wait_cyc(4); chk("scan_c3", {28'd0, kp_if.Col}, 32'h7);
        wait_cyc(4); chk("scan_wrap", {28'd0, kp_if.Col}, 32'hE);

        // key 7 held 50 cycles
        r0 = rises;
        key(2, 0);
        wait_cyc(12); chk("k7_val_early", {29'd0, kp_if.value}, 32'd0);
        wait_cyc(1);
        chk("k7_val",  {29'd0, kp_if.value}, 32'd1);
        chk("k7_dig",  {28'd0, kp_if.digit}, 32'd7);
        chk("k7_trig_pre", {31'd0, kp_if.trig}, 32'd0);
        chk("k7_held", {31'd0, kp_if.KeyHeld}, 32'd1);
        wait_cyc(1); chk("k7_trig1", {31'd0, kp_if.trig}, 32'd1);
        wait_cyc(1); chk("k7_trig2", {31'd0, kp_if.trig}, 32'd1);
        wait_cyc(1); chk("k7_trig_end", {31'd0, kp_if.trig}, 32'd0);
        wait_cyc(34);
        pressed = '0;
        wait_cyc(8); chk("k7_held_rel", {31'd0, kp_if.KeyHeld}, 32'd1);
        wait_cyc(1);
        chk("k7_held_off", {31'd0, kp_if.KeyHeld}, 32'd0);
        chk("k7_next_col", {28'd0, kp_if.Col}, 32'hD);
        chk("k7_dig_kept", {28'd0, kp_if.digit}, 32'd7);
        chk("k7_pulses", rises - r0, 32'd1);

        // sub: 5-cycle bounce, then 30-cycle press
        wait_cyc(10);
        r0 = rises;
        key(1, 3); wait_cyc(5); pressed = '0;
        wait_cyc(20);
        chk("sub_bounce_pulses", rises - r0, 32'd0);
        key(1, 3); wait_cyc(30); pressed = '0;
        wait_cyc(20);
        chk("sub_val", {29'd0, kp_if.value}, 32'd3);
        chk("sub_pulses", rises - r0, 32'd1);

        // 2 and 5 together share column 1: rejected until 5 lifts
        r0 = rises;
        key(0, 1); key(1, 1);
        wait_cyc(40);
        chk("multi_pulses", rises - r0, 32'd0);
        chk("multi_val", {29'd0, kp_if.value}, 32'd3);
        pressed[1*4+1] = 1'b0;
        wait_cyc(30);
        pressed = '0;
        wait_cyc(20);
        chk("k2_val", {29'd0, kp_if.value}, 32'd1);
        chk("k2_dig", {28'd0, kp_if.digit}, 32'd2);
        chk("k2_pulses", rises - r0, 32'd1);

        // equals, reset while strobing
        key(2, 3);
        for (int i = 0; i < 60 && !kp_if.trig; i++) wait_cyc(1);
        chk("eq_trig_seen", {31'd0, kp_if.trig}, 32'd1);
        chk("eq_val", {29'd0, kp_if.value}, 32'd4);
        Reset = 1'b1;
        #1;
        chk("eq_rst_trig", {31'd0, kp_if.trig}, 32'd0);
        chk("eq_rst_val",  {29'd0, kp_if.value}, 32'd0);
        chk("eq_rst_col",  {28'd0, kp_if.Col}, 32'hE);
        chk("eq_rst_held", {31'd0, kp_if.KeyHeld}, 32'd0);
        wait_cyc(2);

        // 9 held from reset release: strobe entries at edges 21, 61, 101, 141
        pressed = '0;
        key(2, 2);
        Reset = 1'b0;
        r0 = rises;
        wait_cyc(150);
        pressed = '0;
        wait_cyc(20);
`ifdef AUTO_REPEAT_EN
        exp9 = 4;
`else
        exp9 = 1;
`endif
        chk("k9_pulses", rises - r0, 32'(exp9));
        chk("k9_dig", {28'd0, kp_if.digit}, 32'd9);

        // add never repeats
        r0 = rises;
        key(0, 3);
        wait_cyc(130);
        pressed = '0;
        wait_cyc(20);
        chk("add_pulses", rises - r0, 32'd1);
        chk("add_val", {29'd0, kp_if.value}, 32'd2);
        chk("add_dig_kept", {28'd0, kp_if.digit}, 32'd9);

        wait_cyc(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
